// File: rtl/pio_in_edge.sv
// Avalon-MM input port: synchronised WIDTH-bit input with per-bit edge capture
// (write-1-to-clear), interrupt mask and a level irq to the CPU.
module pio_in_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_MODE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_pipe;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      read_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_pipe <= '0;
      prev      <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], in_port};
      prev      <= sync;
    end
  end

  assign sync = sync_pipe[SYNC_STAGES-1];

  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0)      edge_hit = sync & ~prev;
    else if (EDGE_TYPE == 1) edge_hit = ~sync & prev;
    else                     edge_hit = sync ^ prev;
  end

  assign wr_en      = chipselect & ~write_n;
  assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A fresh edge takes priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      edgecapture <= edge_hit | (edgecapture & ~clear_bits);
      if (wr_en && address == 2'd1)
        irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux[WIDTH-1:0] = sync;
      2'd1:    read_mux[WIDTH-1:0] = irqmask;
      2'd3:    read_mux[WIDTH-1:0] = edgecapture;
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= read_mux;
  end

  generate
    if (IRQ_MODE == 1) begin : g_irq_level
      assign irq = |(sync & irqmask);
    end else begin : g_irq_edge
      assign irq = |(edgecapture & irqmask);
    end
  endgenerate

endmodule

// File: tb/tb_pio_in_edge.sv
// Bench for pio_in_edge: two configurations driven from one bus, checked against
// a delay-line reference model, register vectors and directed corner sequences.
module tb_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata, readdata1;
  logic        irq, irq1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq));

  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata1), .irq(irq1));

  // Reference model: h is the history of sampled inputs, h[0] newest.
  typedef struct packed {
    logic [4:0][7:0] h;
    logic [7:0]      mask;
    logic [7:0]      cap;
    logic [31:0]     rd;
  } mst_t;

  function automatic mst_t mstep(mst_t s, int st, int et, logic [1:0] a, logic cs,
                                 logic wn, logic [31:0] wd, logic [7:0] inp);
    mst_t n = s;
    logic [7:0] sy = s.h[st-1];
    logic [7:0] pv = s.h[st];
    logic [7:0] ev;
    logic wr = cs & ~wn;
    if (et == 0)      ev = sy & ~pv;
    else if (et == 1) ev = ~sy & pv;
    else              ev = sy ^ pv;
    case (a)
      2'd0:    n.rd = {24'h0, sy};
      2'd1:    n.rd = {24'h0, s.mask};
      2'd3:    n.rd = {24'h0, s.cap};
      default: n.rd = 32'h0;
    endcase
    n.cap = ev | (s.cap & ~((wr && a == 2'd3) ? wd[7:0] : 8'h00));
    if (wr && a == 2'd1) n.mask = wd[7:0];
    for (int i = 4; i > 0; i--) n.h[i] = s.h[i-1];
    n.h[0] = inp;
    return n;
  endfunction

  mst_t m0 = '0;
  mst_t m1 = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0 = '0;
      m1 = '0;
    end else begin
      m0 = mstep(m0, 2, 0, address, chipselect, write_n, writedata, in_port);
      m1 = mstep(m1, 3, 2, address, chipselect, write_n, writedata, in_port);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_rd0", readdata, m0.rd);
    chk("model_irq0", {31'h0, irq}, {31'h0, |(m0.cap & m0.mask)});
    chk("model_rd1", readdata1, m1.rd);
    chk("model_irq1", {31'h0, irq1}, {31'h0, |(m1.h[2] & m1.mask)});
  end

  task automatic idle(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  a;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{2'd1, 1'b1, 1'b0, 32'h0000005A, 32'h00};
    tbl[1]  = '{2'd1, 1'b0, 1'b1, 32'h00000000, 32'h5A};
    tbl[2]  = '{2'd1, 1'b0, 1'b0, 32'h000000FF, 32'h5A};
    tbl[3]  = '{2'd1, 1'b0, 1'b1, 32'h00000000, 32'h5A};
    tbl[4]  = '{2'd1, 1'b1, 1'b1, 32'h00000033, 32'h5A};
    tbl[5]  = '{2'd1, 1'b0, 1'b1, 32'h00000000, 32'h5A};
    tbl[6]  = '{2'd0, 1'b0, 1'b1, 32'h00000000, 32'hA5};
    tbl[7]  = '{2'd0, 1'b1, 1'b0, 32'h00000012, 32'hA5};
    tbl[8]  = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00};
    tbl[9]  = '{2'd2, 1'b0, 1'b1, 32'h00000000, 32'h00};
    tbl[10] = '{2'd3, 1'b0, 1'b1, 32'h00000000, 32'h00};
    tbl[11] = '{2'd1, 1'b1, 1'b0, 32'hFFFFFF00, 32'h5A};
    tbl[12] = '{2'd1, 1'b0, 1'b1, 32'h00000000, 32'h00};

    reset_n = 1'b0; in_port = 8'hFF; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // Reset defaults and the rising capture of inputs held high through reset
    repeat (3) @(negedge clk);
    chk("rst_rd", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    address = 2'd1;
    @(negedge clk); chk("rst_mask", readdata, 32'h0);
    address = 2'd3;
    @(negedge clk);
    @(negedge clk); chk("cap_early", readdata, 32'h0);
    @(negedge clk); chk("cap_rst_edge", readdata, 32'hFF);
    wr(2'd3, 32'hFF); idle(1);

    // Data path latency
    in_port = 8'h00; idle(4);
    in_port = 8'hA5; address = 2'd0;
    @(negedge clk); chk("lat_k", readdata, 32'h0);
    @(negedge clk); chk("lat_k1", readdata, 32'h0);
    @(negedge clk); chk("lat_k2", readdata, 32'hA5);
    address = 2'd2;
    @(negedge clk); chk("rsvd_rd", readdata, 32'h0);
    idle(3); wr(2'd3, 32'hFFFFFFFF); idle(1);

    // Register-level vectors, input held steady
    for (int i = 0; i < 13; i++) begin
      address = tbl[i].a; chipselect = tbl[i].cs;
      write_n = tbl[i].wn; writedata = tbl[i].wd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), readdata, tbl[i].exp);
    end
    idle(1);

    // Edge capture and write-1-to-clear on bit 3
    in_port = 8'hAD; idle(4);
    address = 2'd3;
    @(negedge clk); chk("cap_b3", readdata, 32'h08);
    wr(2'd3, 32'h00);
    @(negedge clk); chk("w1c_zero", readdata, 32'h08);
    wr(2'd3, 32'h08);
    @(negedge clk); chk("w1c_one", readdata, 32'h00);
    in_port = 8'hA5; idle(4);
    chk("fall_noset", readdata, 32'h00);

    // Edge arriving in the same cycle as its clear
    in_port = 8'hA4; idle(4);
    in_port = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h01;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk); chk("set_wins", readdata, 32'h01);
    wr(2'd3, 32'h01);
    @(negedge clk); chk("clr_after", readdata, 32'h00);

    // irq, edge mode (dut) and level mode (dut1)
    wr(2'd1, 32'h04);
    in_port = 8'hA7; idle(4);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    in_port = 8'hA3; idle(4);
    in_port = 8'hA7; idle(4);
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h04);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    wr(2'd1, 32'h01);
    in_port = 8'hA6; idle(5);
    chk("lvl_lo", {31'h0, irq1}, 32'h0);
    in_port = 8'hA7; idle(2);
    chk("lvl_early", {31'h0, irq1}, 32'h0);
    idle(1);
    chk("lvl_hi", {31'h0, irq1}, 32'h1);
    in_port = 8'hA6; idle(3);
    chk("lvl_fall", {31'h0, irq1}, 32'h0);

    // Asynchronous reset in mid-operation
    wr(2'd3, 32'hFF); wr(2'd1, 32'hFF);
    in_port = 8'h00; idle(5);
    wr(2'd3, 32'hFF);
    in_port = 8'h3C; idle(5);
    address = 2'd3;
    @(negedge clk);
    chk("cap_3c", readdata, 32'h3C);
    chk("irq_3c", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rd", readdata, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    chk("arst_irq1", {31'h0, irq1}, 32'h0);
    #1 reset_n = 1'b1;
    address = 2'd1;
    @(negedge clk);
    @(negedge clk); chk("arst_mask", readdata, 32'h0);
    address = 2'd3;
    @(negedge clk); chk("arst_cap", readdata, 32'h0);

    // Randomised traffic, checked by the model on every cycle
    for (int i = 0; i < 400; i++) begin
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      @(negedge clk);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
